// File: rtl/prog_sequencer_pkg.sv
// Shared sizes, state encoding and instruction layout
// for the nibble-entered program sequencer.
package prog_sequencer_pkg;

  localparam int SEQ_DEPTH   = 16;
  localparam int SEQ_AW      = 4;
  localparam int SEQ_TIMEOUT = 255;
  localparam int TMO_W       = 8;
  localparam int NIB_W       = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_NEXT  = 3'd3,
    S_PAUSE = 3'd4,
    S_DONE  = 3'd5,
    S_HALT  = 3'd6
  } seq_state_t;

  // {op, rd1, rd2, wr} = [15:12], [11:8], [7:4], [3:0]
  typedef struct packed {
    logic [3:0] op;
    logic [3:0] rd1;
    logic [3:0] rd2;
    logic [3:0] wr;
  } instr_t;

  function automatic logic [TMO_W-1:0] sat_inc(
    input logic [TMO_W-1:0] v
  );
    return (&v) ? v : v + TMO_W'(1);
  endfunction

endpackage

// File: rtl/prog_sequencer_imem.sv
// Program store: one synchronous write port,
// one combinational read port.
module prog_sequencer_imem
  import prog_sequencer_pkg::*;
#(
  parameter int DEPTH = SEQ_DEPTH,
  parameter int AW    = SEQ_AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  instr_t        wdata,
  input  logic [AW-1:0] raddr,
  output instr_t        rdata
);

  // Contents deliberately survive reset.
  instr_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/prog_sequencer.sv
// Captures a short program from the switches and replays it
// one instruction at a time through the datapath.
module prog_sequencer
  import prog_sequencer_pkg::*;
#(
  parameter int DEPTH   = SEQ_DEPTH,
  parameter int AW      = SEQ_AW,
  parameter int TIMEOUT = SEQ_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    nib_in,
  input  logic          ent_btn,
  input  logic          run_btn,
  input  logic          step_btn,
  input  logic          exec_done,
  input  logic          flowcheck,
  output logic [3:0]    op,
  output logic [3:0]    rd1,
  output logic [3:0]    rd2,
  output logic [3:0]    wr,
  output logic          issue,
  output logic [AW-1:0] pc,
  output logic [AW:0]   count,
  output logic [1:0]    nib_idx,
  output logic [2:0]    seq_state,
  output logic          fault
);

  localparam logic [AW:0]      CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);

  seq_state_t       state_q, state_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic [AW:0]      count_q, count_d;
  logic [1:0]       nib_idx_q, nib_idx_d;
  logic [11:0]      hold_q, hold_d;
  logic             fault_q, fault_d;
  logic             run_mode_q, run_mode_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  instr_t           fields_q, fields_d;
  logic [2:0]       btn_q, btn_d;

  logic             ent_rise;
  logic             run_rise;
  logic             step_rise;
  logic             mem_we;
  logic [AW:0]      pc_inc;
  instr_t           wr_word;
  instr_t           rd_word;

  // Button order in btn_q: {ent, run, step}
  assign btn_d     = {ent_btn, run_btn, step_btn};
  assign ent_rise  = ent_btn  & ~btn_q[2];
  assign run_rise  = run_btn  & ~btn_q[1];
  assign step_rise = step_btn & ~btn_q[0];

  assign pc_inc  = {1'b0, pc_q} + (AW+1)'(1);
  assign wr_word = instr_t'({hold_q, nib_in});

  prog_sequencer_imem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_imem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (count_q[AW-1:0]),
    .wdata (wr_word),
    .raddr (pc_d),
    .rdata (rd_word)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    count_d    = count_q;
    nib_idx_d  = nib_idx_q;
    hold_d     = hold_q;
    fault_d    = fault_q;
    run_mode_d = run_mode_q;
    tmo_d      = tmo_q;
    mem_we     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ent_rise) begin
          if (count_q != CNT_FULL) begin
            if (nib_idx_q == 2'd3) begin
              mem_we    = 1'b1;
              count_d   = count_q + (AW+1)'(1);
              nib_idx_d = 2'd0;
            end else begin
              hold_d    = {hold_q[7:0], nib_in};
              nib_idx_d = nib_idx_q + 2'd1;
            end
          end
        end else if ((run_rise || step_rise) &&
                     count_q != '0 && nib_idx_q == 2'd0) begin
          pc_d       = '0;
          run_mode_d = run_rise;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A completion on the last allowed cycle still counts.
        if (exec_done) begin
          if (flowcheck) begin
            fault_d = 1'b1;
            state_d = S_HALT;
          end else begin
            state_d = S_NEXT;
          end
        end else if (tmo_q == TMO_MAX) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          tmo_d = sat_inc(tmo_q);
        end
      end
      S_NEXT: begin
        if (pc_inc == count_q) begin
          state_d = S_DONE;
        end else begin
          pc_d    = pc_inc[AW-1:0];
          state_d = run_mode_q ? S_ISSUE : S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (run_rise) begin
          run_mode_d = 1'b1;
          state_d    = S_ISSUE;
        end else if (step_rise) begin
          state_d = S_ISSUE;
        end
      end
      S_DONE, S_HALT: begin
        if (run_rise) begin
          pc_d       = '0;
          fault_d    = 1'b0;
          run_mode_d = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Fields load on the edge into ISSUE so they are valid with the pulse.
  always_comb begin
    fields_d = fields_q;
    if (state_d == S_ISSUE) begin
      fields_d = rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      count_q    <= '0;
      nib_idx_q  <= 2'd0;
      hold_q     <= '0;
      fault_q    <= 1'b0;
      run_mode_q <= 1'b0;
      tmo_q      <= '0;
      fields_q   <= '0;
      btn_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      nib_idx_q  <= nib_idx_d;
      hold_q     <= hold_d;
      fault_q    <= fault_d;
      run_mode_q <= run_mode_d;
      tmo_q      <= tmo_d;
      fields_q   <= fields_d;
      btn_q      <= btn_d;
    end
  end

  assign op        = fields_q.op;
  assign rd1       = fields_q.rd1;
  assign rd2       = fields_q.rd2;
  assign wr        = fields_q.wr;
  assign issue     = (state_q == S_ISSUE);
  assign pc        = pc_q;
  assign count     = count_q;
  assign nib_idx   = nib_idx_q;
  assign seq_state = state_q;
  assign fault     = fault_q;

endmodule
